// File: rtl/vga_address_gen_if.sv
// Pixel timing inputs and frame memory read outputs of vga_address_gen.
// The addr_err signal exists only when VGA_ADDR_BOUNDS_EN is defined.
interface vga_address_gen_if #(
  parameter int ADDR_W = 19,
  parameter int DIM_W  = 16
);
  logic              pixel_tick;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              interpolacion;
  logic [DIM_W-1:0]  dimensiones;
  logic [ADDR_W-1:0] DataAdr_out;
  logic              enable_pixel;
  logic              frame_start;
`ifdef VGA_ADDR_BOUNDS_EN
  logic              addr_err;
`endif

  // Timing source and pixel consumer side.
  modport master (
    output pixel_tick, x, y, interpolacion, dimensiones,
    input  DataAdr_out, enable_pixel, frame_start
`ifdef VGA_ADDR_BOUNDS_EN
    , input addr_err
`endif
  );

  // Address generator side.
  modport slave (
    input  pixel_tick, x, y, interpolacion, dimensiones,
    output DataAdr_out, enable_pixel, frame_start
`ifdef VGA_ADDR_BOUNDS_EN
    , output addr_err
`endif
  );
endinterface

// File: rtl/vga_address_gen.sv
// Frame memory read address generator for a square image window on a VGA
// raster. During vertical blanking it points at the dimension word and
// latches the image size and mode; inside the visible window it walks the
// image addresses one per enabled pixel.
// Optional feature macro: VGA_ADDR_BOUNDS_EN adds a sticky addr_err output
// and suppresses enable_pixel for any address past the end of the image.
module vga_address_gen #(
  parameter int ADDR_W      = 19,
  parameter int DIM_W       = 16,
  parameter int H_START     = 145,
  parameter int V_START     = 35,
  parameter int DIM_ADDR    = 2,
  parameter int BASE_ORIG   = 6,
  parameter int BASE_INTERP = 125016,
  parameter int MAX_DIM     = 480
) (
  input logic               clk,
  input logic               rst,
  vga_address_gen_if.slave  bus
);

  localparam int WIN_W = DIM_W + 2;
  localparam int CMP_W = WIN_W + 1;

  typedef enum logic [1:0] {S_VBLANK, S_ACTIVE, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DIM_W-1:0]  dim_reg;
  logic              mode_reg;
  logic [ADDR_W-1:0] data_adr_q;
  logic              enable_q;
  logic              frame_start_q;

  logic [DIM_W-1:0]  dim_clamped;
  logic [WIN_W-1:0]  win;
  logic [CMP_W-1:0]  x_ext;
  logic [CMP_W-1:0]  y_ext;
  logic [CMP_W-1:0]  h_end;
  logic [CMP_W-1:0]  v_end;
  logic              in_vblank;
  logic              in_cols;

`ifdef VGA_ADDR_BOUNDS_EN
  localparam int AREA_W = 2 * WIN_W;
  logic [AREA_W-1:0] area_end;
  logic              over_bound;
  logic              addr_err_q;
`endif

  // Window side and raster position decode from the frozen frame settings.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    dim_clamped = (bus.dimensiones > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : bus.dimensiones;
    if (!mode_reg)
      win = WIN_W'(dim_reg);
    else if (dim_reg < DIM_W'(4))
      win = '0;
    else
      win = WIN_W'(dim_reg >> 2) * WIN_W'(3) - WIN_W'(2);
    x_ext     = CMP_W'(bus.x);
    y_ext     = CMP_W'(bus.y);
    h_end     = CMP_W'(H_START) + CMP_W'(win);
    v_end     = CMP_W'(V_START) + CMP_W'(win);
    in_vblank = (y_ext < CMP_W'(V_START));
    in_cols   = (x_ext >= CMP_W'(H_START)) && (x_ext < h_end);
  end

`ifdef VGA_ADDR_BOUNDS_EN
  // First address past the image for the mode of the current frame.
  assign area_end   = (mode_reg ? AREA_W'(BASE_INTERP) : AREA_W'(BASE_ORIG))
                      + AREA_W'(win) * AREA_W'(win);
  assign over_bound = (AREA_W'(addr_cnt) >= area_end);
`endif

  // Frame FSM, address counter and registered outputs, advanced per pixel tick.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values.
    if (rst) begin
      state         <= S_VBLANK;
      addr_cnt      <= ADDR_W'(BASE_ORIG);
      dim_reg       <= '0;
      mode_reg      <= 1'b0;
      data_adr_q    <= ADDR_W'(DIM_ADDR);
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_ADDR_BOUNDS_EN
      addr_err_q    <= 1'b0;
`endif
    end else begin
      // frame_start is a single-clk pulse even when ticks are sparse.
      frame_start_q <= 1'b0;
      if (bus.pixel_tick) begin
        if (in_vblank) begin
          // Any blanking row restarts the frame, whatever the current state.
          state      <= S_VBLANK;
          data_adr_q <= ADDR_W'(DIM_ADDR);
          enable_q   <= 1'b0;
          dim_reg    <= dim_clamped;
          mode_reg   <= bus.interpolacion;
          addr_cnt   <= bus.interpolacion ? ADDR_W'(BASE_INTERP) : ADDR_W'(BASE_ORIG);
`ifdef VGA_ADDR_BOUNDS_EN
          addr_err_q <= 1'b0;
`endif
        end else begin
          data_adr_q <= addr_cnt;
          enable_q   <= 1'b0;
          case (state)
            // The entry tick only opens the frame; rows start at x=0, outside the window.
            S_VBLANK: begin
              state         <= S_ACTIVE;
              frame_start_q <= 1'b1;
            end
            S_ACTIVE: begin
              if (y_ext >= v_end) begin
                state <= S_DONE;
              end else if (in_cols) begin
`ifdef VGA_ADDR_BOUNDS_EN
                if (over_bound) addr_err_q <= 1'b1;
                else            enable_q   <= 1'b1;
`else
                enable_q <= 1'b1;
`endif
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
            end
            S_DONE:  state <= S_DONE;
            default: state <= S_VBLANK;
          endcase
        end
      end
    end
  end

  assign bus.DataAdr_out  = data_adr_q;
  assign bus.enable_pixel = enable_q;
  assign bus.frame_start  = frame_start_q;
`ifdef VGA_ADDR_BOUNDS_EN
  assign bus.addr_err     = addr_err_q;
`endif

endmodule
